ram_in_serial_out: RTL and testbench
====================================

RAM_IN_SERIAL_OUT -- requirements
Module: ram_in_serial_out

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the width of each stored item.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 6, meaning a RAM depth of 2^ADDRESS_WIDTH items.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clk input 1 is the sole clock; rst input 1 is the synchronous active-high reset.
REQ-004 SHALL have wr_addr, input, ADDRESS_WIDTH, the random-access write address.
REQ-005 SHALL have wr_data, input, DATA_WIDTH, the write data.
REQ-006 SHALL have wr_en, input, 1, which writes wr_data to wr_addr on the same clock edge.
REQ-007 SHALL have start, input, 1, a single-cycle request to begin streaming.
REQ-008 SHALL have start_addr, input, ADDRESS_WIDTH, the first address to stream, sampled when start is accepted.
REQ-009 SHALL have num_item, input, ADDRESS_WIDTH+1, the number of items to stream (0..2^ADDRESS_WIDTH), sampled when start is accepted.
REQ-010 SHALL have data_out, output, DATA_WIDTH, the serial output item.
REQ-011 SHALL have data_out_valid, output, 1, which is high when data_out holds a valid item.
REQ-012 SHALL have data_out_ready, input, 1, the downstream acceptance signal; a transfer occurs on an edge where valid and ready are both high.
REQ-013 SHALL have busy, output, 1, which is high from the cycle after an accepted start until done.
REQ-014 SHALL have done, output, 1, a single-cycle pulse after the last item is transferred.

Function
REQ-015 SHALL accept start only in IDLE; start SHALL be ignored while busy.
REQ-016 SHALL implement the FSM IDLE->RUN on accepted start with num_item!=0, RUN->DONE when the num_item-th transfer occurs, and DONE->IDLE unconditionally after one cycle.
REQ-017 SHALL, on an accepted start with num_item==0, go IDLE->DONE, pulse done one cycle after start, and produce no data_out_valid.
REQ-018 SHALL present the first read address on the cycle after start and assert data_out_valid first in the 2nd cycle after the start cycle (1-cycle dpram read latency).
REQ-019 SHALL stream items from start_addr, start_addr+1, ..., with the address wrapping modulo 2^ADDRESS_WIDTH.
REQ-020 SHALL sustain one transfer per cycle while data_out_ready is held high, with no bubbles after the first item.
REQ-021 SHALL, when data_out_ready is low, hold data_out and data_out_valid stable, with no item lost or duplicated; a 2-entry skid buffer absorbs the in-flight read.
REQ-022 SHALL issue a read only while (items issued) < num_item and the skid buffer has free space counting in-flight reads; there SHALL be no over-read past num_item.
REQ-023 SHALL accept writes at any time, including during RUN.
REQ-024 SHALL, when a write and a read hit the same address in the same cycle, return the pre-write contents (read-first).
REQ-025 SHALL use issue and transfer counters of ADDRESS_WIDTH+1 bits so that num_item=2^ADDRESS_WIDTH streams the full RAM exactly once.
REQ-026 SHALL assert done only in DONE, for exactly one cycle; busy SHALL be low in DONE.

Reset
REQ-027 SHALL, on rst, set the FSM to IDLE, clear all counters and skid buffer, and drive data_out_valid=0, busy=0, done=0, data_out=0 on the following cycle.
REQ-028 SHALL abort any stream on rst mid-operation; no further valid SHALL appear until a new start is accepted.
REQ-029 SHALL leave RAM contents unspecified after reset, and the bench SHALL not rely on them.

Structure
REQ-030 SHALL keep FSM state encodings as localparams in the module; no shared package is required.
REQ-031 SHALL instantiate the existing dpram sub-module (DATA_WIDTH, ADDRESS_WIDTH passed through), with write port = wr_addr/wr_data/wr_en and read port = internal stream address.

Verification
REQ-032 Bench SHALL cover: write 0..63 with value=addr, start start_addr=0 num_item=64, ready=1 -> 64 consecutive valid cycles, data 0..63, first valid 2 cycles after start, done 1 cycle after last transfer.
REQ-033 Bench SHALL cover: start_addr=60 num_item=8 -> data 60,61,62,63,0,1,2,3 (wrap).
REQ-034 Bench SHALL cover: num_item=16 with ready toggled pseudo-randomly -> exactly 16 transfers, in order, data stable while ready low.
REQ-035 Bench SHALL cover: num_item=0 -> no valid, done pulses 1 cycle after start, busy stays low.
REQ-036 Bench SHALL cover: second start during RUN -> ignored, original stream completes unchanged; rst asserted mid-stream -> valid=0, busy=0 next cycle.
REQ-037 Bench SHALL cover: write addr 10 := 0xAA while streaming from 0 before address 10 is read -> 0xAA output at position 10.

Source files
------------

// File: rtl/ram_in_serial_out_pkg.sv
// Shared constants for the RAM-to-stream block: output skid buffer sizing.
package ram_in_serial_out_pkg;

    localparam int unsigned SkidDepth = 2;
    localparam int unsigned SkidCntW  = $clog2(SkidDepth + 1);

endpackage

// File: rtl/ram_in_serial_out_dpram.sv
// Simple dual-port RAM: one write port, one registered read port (read-first on collision).
module ram_in_serial_out_dpram #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 6
) (
    input  logic                     clk_i,
    input  logic                     wr_en_i,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0]    wr_data_i,
    input  logic                     rd_en_i,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0]    rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDRESS_WIDTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Both ports update with non-blocking writes, so a same-address read sees old data.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ram_in_serial_out.sv
// Streams num_item words from a dual-port RAM starting at start_addr over a valid/ready port.
module ram_in_serial_out
    import ram_in_serial_out_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     wr_en,
    input  logic                     start,
    input  logic [ADDRESS_WIDTH-1:0] start_addr,
    input  logic [ADDRESS_WIDTH:0]   num_item,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_out_valid,
    input  logic                     data_out_ready,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned CntW = ADDRESS_WIDTH + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [CntW-1:0]          num_q, num_d;
    logic [CntW-1:0]          issued_q, issued_d;
    logic [CntW-1:0]          xfer_cnt_q, xfer_cnt_d;
    logic                     rd_vld_q, rd_vld_d;
    logic [DATA_WIDTH-1:0]    skid_q [SkidDepth];
    logic [DATA_WIDTH-1:0]    skid_d [SkidDepth];
    logic [SkidCntW-1:0]      cnt_q, cnt_d;

    logic                     start_ok, rd_en, out_vld, xfer, push, pop;
    logic [SkidCntW-1:0]      occupancy;
    logic [DATA_WIDTH-1:0]    rd_data, head;

    ram_in_serial_out_dpram #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_dpram (
        .clk_i    (clk),
        .wr_en_i  (wr_en),
        .wr_addr_i(wr_addr),
        .wr_data_i(wr_data),
        .rd_en_i  (rd_en),
        .rd_addr_i(rd_addr_q),
        .rd_data_o(rd_data)
    );

    // Credit check counts the in-flight read so the skid buffer can never overflow.
    assign occupancy = cnt_q + SkidCntW'(rd_vld_q);
    assign start_ok  = (state_q == StIdle) && start;
    assign rd_en     = (state_q == StRun) && (issued_q != num_q) &&
                       (occupancy < SkidCntW'(SkidDepth));

    // Skid head has priority; an empty skid lets the RAM output flow straight through.
    assign out_vld   = (state_q == StRun) && (rd_vld_q || (cnt_q != '0));
    assign head      = (cnt_q != '0) ? skid_q[0] : rd_data;
    assign xfer      = out_vld && data_out_ready;
    assign push      = rd_vld_q && !((cnt_q == '0) && xfer);
    assign pop       = xfer && (cnt_q != '0);

    assign data_out       = out_vld ? head : '0;
    assign data_out_valid = out_vld;
    assign busy           = (state_q == StRun);
    assign done           = (state_q == StDone);

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        num_d      = num_q;
        issued_d   = issued_q;
        xfer_cnt_d = xfer_cnt_q;
        rd_vld_d   = rd_en;
        skid_d     = skid_q;
        cnt_d      = cnt_q;

        if (pop) begin
            skid_d[0] = skid_q[1];
            cnt_d     = cnt_q - SkidCntW'(1);
        end
        if (push) begin
            skid_d[cnt_d[0]] = rd_data;
            cnt_d            = cnt_d + SkidCntW'(1);
        end

        if (rd_en) begin
            rd_addr_d = rd_addr_q + ADDRESS_WIDTH'(1);
            issued_d  = issued_q + CntW'(1);
        end
        if (xfer) begin
            xfer_cnt_d = xfer_cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    rd_addr_d  = start_addr;
                    num_d      = num_item;
                    issued_d   = '0;
                    xfer_cnt_d = '0;
                    state_d    = (num_item == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (xfer && ((xfer_cnt_q + CntW'(1)) == num_q)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rd_addr_q  <= '0;
            num_q      <= '0;
            issued_q   <= '0;
            xfer_cnt_q <= '0;
            rd_vld_q   <= 1'b0;
            cnt_q      <= '0;
            for (int i = 0; i < SkidDepth; i++) begin
                skid_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            num_q      <= num_d;
            issued_q   <= issued_d;
            xfer_cnt_q <= xfer_cnt_d;
            rd_vld_q   <= rd_vld_d;
            cnt_q      <= cnt_d;
            skid_q     <= skid_d;
        end
    end

endmodule

// File: tb/tb_ram_in_serial_out.sv
// Randomized bench for ram_in_serial_out against a memory-array reference model.
module tb_ram_in_serial_out;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 6;
    localparam int unsigned Depth = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   num_item;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic          data_out_ready;
    logic          busy;
    logic          done;

    int unsigned   n_vec = 0;
    int unsigned   n_err = 0;
    logic [DW-1:0] mem_m [Depth];

    always #5 clk = ~clk;

    ram_in_serial_out #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_en         (wr_en),
        .start         (start),
        .start_addr    (start_addr),
        .num_item      (num_item),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .busy          (busy),
        .done          (done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a, input logic [DW-1:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        step();
        wr_en   = 1'b0;
        mem_m[a] = d;
    endtask

    // Runs one stream; optional mid-stream RAM write and stray start at given cycles (-1 = none).
    task automatic run_stream(input int sa, input int n, input int pct, input int wr_cyc,
                              input int wr_a, input logic [DW-1:0] wr_d, input int stray_cyc);
        int            cyc = 0;
        int            got = 0;
        int            last_x = 0;
        bit            first_seen = 1'b0;
        bit            done_seen = 1'b0;
        bit            pv = 1'b0;
        bit            px = 1'b0;
        bit            xfer;
        logic [DW-1:0] pd = '0;

        start          = 1'b1;
        start_addr     = AW'(sa);
        num_item       = (AW + 1)'(n);
        data_out_ready = 1'b0;
        step();
        start = 1'b0;
        cyc   = 1;
        while (!done_seen && cyc < 600) begin
            data_out_ready = ($urandom_range(99) < pct);
            if (cyc == stray_cyc) begin
                start      = 1'b1;
                start_addr = AW'(33);
                num_item   = (AW + 1)'(3);
            end else begin
                start = 1'b0;
            end
            wr_en   = (cyc == wr_cyc);
            wr_addr = AW'(wr_a);
            wr_data = wr_d;

            if (data_out_valid && !first_seen) begin
                first_seen = 1'b1;
                check_eq("first_valid_cycle", cyc, 2);
            end
            if (pv && !px) begin
                check_eq("hold_valid", data_out_valid, 1);
                check_eq("hold_data", data_out, pd);
            end
            if (data_out_valid && got >= n) begin
                check_eq("over_read_valid", data_out_valid, 0);
            end
            xfer = data_out_valid && data_out_ready;
            if (xfer && got < n) begin
                check_eq($sformatf("item%0d_from_%0d", got, sa), data_out,
                         mem_m[(sa + got) % Depth]);
            end
            if (done) begin
                done_seen = 1'b1;
                check_eq("done_cycle", cyc, last_x + 1);
                check_eq("transfer_count", got, n);
                check_eq("busy_in_done", busy, 0);
                if (pct >= 100) begin
                    check_eq("done_full_rate", cyc, (n == 0) ? 1 : n + 2);
                end
            end else begin
                check_eq("busy", busy, (n != 0));
            end

            if (xfer) begin
                got++;
                last_x = cyc;
            end
            pv = data_out_valid;
            px = xfer;
            pd = data_out;
            if (!done_seen) begin
                step();
                if (wr_en) begin
                    mem_m[wr_a] = wr_d;
                end
                cyc++;
            end
        end
        start = 1'b0;
        wr_en = 1'b0;
        if (!done_seen) begin
            check_eq("stream_timeout", done_seen, 1);
        end
        step();
        check_eq("idle_valid", data_out_valid, 0);
        check_eq("idle_done", done, 0);
    endtask

    initial begin
        rst            = 1'b1;
        wr_en          = 1'b0;
        wr_addr        = '0;
        wr_data        = '0;
        start          = 1'b0;
        start_addr     = '0;
        num_item       = '0;
        data_out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        check_eq("rst_valid", data_out_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_data", data_out, 0);

        for (int a = 0; a < Depth; a++) begin
            write_word(a, DW'(a));
        end

        run_stream(0, 64, 100, -1, 0, 8'h00, -1);
        run_stream(60, 8, 100, -1, 0, 8'h00, -1);
        run_stream(20, 16, 50, -1, 0, 8'h00, -1);
        run_stream(7, 0, 100, -1, 0, 8'h00, -1);
        run_stream(5, 20, 100, -1, 0, 8'h00, 6);
        run_stream(0, 64, 100, 3, 10, 8'hAA, -1);
        check_eq("mem10_model", mem_m[10], 8'hAA);

        // Abort mid-stream.
        start          = 1'b1;
        start_addr     = '0;
        num_item       = (AW + 1)'(40);
        data_out_ready = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        check_eq("pre_rst_valid", data_out_valid, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("abort_valid", data_out_valid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_data", data_out, 0);
        repeat (10) begin
            step();
            check_eq("post_abort_quiet", {data_out_valid, busy, done}, 0);
        end

        for (int a = 0; a < Depth; a++) begin
            write_word(a, DW'($urandom));
        end
        for (int r = 0; r < 8; r++) begin
            run_stream($urandom_range(Depth - 1), $urandom_range(Depth, 1),
                       $urandom_range(100, 20), -1, 0, 8'h00, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
